// File: rtl/dec_counter_pkg.sv
// Shared types and constants for the dec_counter loadable down-counter.
package dec_counter_pkg;

  localparam int DEFAULT_SIZE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dec_counter_reg.sv
// Count register for dec_counter: load, decrement-to-zero or hold, with zero/one flags.
module dec_counter_reg
  import dec_counter_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  logic [SIZE-1:0] ld_val,
  input  logic            dec,
  output logic [SIZE-1:0] count,
  output logic            zero,
  output logic            one
);

  // The decrement is suppressed at zero so the count can never wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (ld) begin
      count <= ld_val;
    end else if (dec && (count != '0)) begin
      count <= count - SIZE'(1);
    end
  end

  assign zero = (count == '0);
  assign one  = (count == SIZE'(1));

endmodule

// File: rtl/dec_counter.sv
// Loadable down-counter with a one-cycle done pulse at terminal count.
// Optional periodic reload is enabled by defining AUTO_RELOAD_EN.
module dec_counter
  import dec_counter_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            sck,
  input  logic            rst,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic            sub1,
  output logic [SIZE-1:0] count,
  output logic            busy,
  output logic            done,
  output logic            zero
);

  state_t          state;
  state_t          state_nxt;
  logic            reg_ld;
  logic [SIZE-1:0] reg_val;
  logic            reg_dec;
  logic            cnt_one;

`ifdef AUTO_RELOAD_EN
  logic [SIZE-1:0] reload;

  // Remembers the last accepted preset so DONE can restart the same span.
  always_ff @(posedge sck) begin
    if (!rst) begin
      reload <= '0;
    end else if (load) begin
      reload <= load_val;
    end
  end
`endif

  always_ff @(posedge sck) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A load is honoured in every state and overrides strobes and any reload.
  always_comb begin
    state_nxt = state;
    reg_ld    = 1'b0;
    reg_val   = load_val;
    reg_dec   = 1'b0;
    if (load) begin
      reg_ld    = 1'b1;
      reg_val   = load_val;
      state_nxt = (load_val != '0) ? ST_RUN : ST_DONE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_IDLE;
        end
        ST_RUN: begin
          if (sub1) begin
            reg_dec = 1'b1;
            if (cnt_one || zero) begin
              state_nxt = ST_DONE;
            end
          end
        end
        ST_DONE: begin
`ifdef AUTO_RELOAD_EN
          reg_ld    = 1'b1;
          reg_val   = reload;
          state_nxt = (reload != '0) ? ST_RUN : ST_IDLE;
`else
          state_nxt = ST_IDLE;
`endif
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  dec_counter_reg #(
    .SIZE(SIZE)
  ) u_reg (
    .clk   (sck),
    .rst   (rst),
    .ld    (reg_ld),
    .ld_val(reg_val),
    .dec   (reg_dec),
    .count (count),
    .zero  (zero),
    .one   (cnt_one)
  );

endmodule
